// File: rtl/mips_regfile_wb.sv
// mips_regfile_wb: 32 x 32-bit architectural register file at the end of the
// writeback path. It has two combinational read ports with a per-byte-lane
// write-through bypass and a registered debug read port. r0 is hardwired to zero.
module mips_regfile_wb #(
    parameter int RWE_SIZE = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [4:0]          WB_inst_rd_in,
    input  logic [RWE_SIZE-1:0] WB_RegWrite_in,
    input  logic [31:0]         WB_RF_Wdata_in,
    input  logic [4:0]          ID_rs_addr,
    input  logic [4:0]          ID_rt_addr,
    output logic [31:0]         ID_rs_data,
    output logic [31:0]         ID_rt_data,
    input  logic [4:0]          DBG_addr,
    output logic [31:0]         DBG_data
);

    // Expand four lane enables into a 32-bit byte mask.
    function automatic logic [31:0] byte_mask(input logic [3:0] lanes);
        byte_mask = {{8{lanes[3]}}, {8{lanes[2]}}, {8{lanes[1]}}, {8{lanes[0]}}};
    endfunction

    // Take new bytes where the mask is set and keep old bytes elsewhere.
    function automatic logic [31:0] lane_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [31:0] mask);
        lane_merge = (new_val & mask) | (old_val & ~mask);
    endfunction

    // Resolve one read port: zero in reset or for r0, bypass on a writeback hit,
    // otherwise plain storage.
    function automatic logic [31:0] read_port(input logic        rst_ok,
                                              input logic [4:0]  addr,
                                              input logic [4:0]  wb_rd,
                                              input logic [31:0] wb_data,
                                              input logic [31:0] wb_mask,
                                              input logic [31:0] stored);
        if (!rst_ok) begin
            read_port = 32'd0;
        end else if (addr == 5'd0) begin
            read_port = 32'd0;
        end else if (addr == wb_rd) begin
            read_port = lane_merge(stored, wb_data, wb_mask);
        end else begin
            read_port = stored;
        end
    endfunction

    logic [31:0] regs_r [0:31];
    logic [31:0] dbg_data_r;
    logic [3:0]  lane_en_s;
    logic [31:0] wr_mask_s;
    logic        wr_en_s;
    logic [31:0] rs_data_s;
    logic [31:0] rt_data_s;

    // Normalise the write-enable width to four byte-lane enables.
    generate
        if (RWE_SIZE == 1) begin : g_rwe_word
            assign lane_en_s = {4{WB_RegWrite_in[0]}};
        end else if (RWE_SIZE == 4) begin : g_rwe_lane
            assign lane_en_s = WB_RegWrite_in;
        end else begin : g_rwe_bad
            $error("mips_regfile_wb: RWE_SIZE must be 1 or 4");
        end
    endgenerate

    assign wr_mask_s = byte_mask(lane_en_s);
    assign wr_en_s   = (WB_inst_rd_in != 5'd0) && (lane_en_s != 4'd0);

    // Storage update: reset clears every register, and a write merges the enabled lanes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                regs_r[i] <= 32'd0;
            end
        end else if (wr_en_s) begin
            regs_r[WB_inst_rd_in] <= lane_merge(regs_r[WB_inst_rd_in],
                                                WB_RF_Wdata_in, wr_mask_s);
        end
    end

    // Debug port samples storage only, with no bypass and r0 forced to zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dbg_data_r <= 32'd0;
        end else if (DBG_addr == 5'd0) begin
            dbg_data_r <= 32'd0;
        end else begin
            dbg_data_r <= regs_r[DBG_addr];
        end
    end

    // Both decode read ports, each resolved independently with the lane bypass.
    always_comb begin
        rs_data_s = 32'd0;
        rt_data_s = 32'd0;
        rs_data_s = read_port(rst_n, ID_rs_addr, WB_inst_rd_in, WB_RF_Wdata_in,
                              wr_mask_s, regs_r[ID_rs_addr]);
        rt_data_s = read_port(rst_n, ID_rt_addr, WB_inst_rd_in, WB_RF_Wdata_in,
                              wr_mask_s, regs_r[ID_rt_addr]);
    end

    assign ID_rs_data = rs_data_s;
    assign ID_rt_data = rt_data_s;
    assign DBG_data   = dbg_data_r;

endmodule

// File: tb/tb_mips_regfile_wb.sv
// Directed bench for mips_regfile_wb. A lane-enable instance (RWE_SIZE=4) runs a
// vector table and hand sequences. A word-enable instance (RWE_SIZE=1) shares the
// address and data inputs but has its own enable.
module tb_mips_regfile_wb;

    typedef struct {
        logic [4:0]  rd;
        logic [3:0]  we;
        logic [31:0] wdata;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [31:0] exp_rs;
        logic [31:0] exp_rt;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic [4:0]  rd;
    logic [3:0]  we;
    logic [0:0]  we1;
    logic [31:0] wdata;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dbg;
    logic [31:0] rs4, rt4, dbg4;
    logic [31:0] rs1, rt1, dbg1;

    int total;
    int bad;
    vec_t vecs [15];

    mips_regfile_wb #(.RWE_SIZE(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .WB_inst_rd_in(rd), .WB_RegWrite_in(we), .WB_RF_Wdata_in(wdata),
        .ID_rs_addr(rs), .ID_rt_addr(rt),
        .ID_rs_data(rs4), .ID_rt_data(rt4),
        .DBG_addr(dbg), .DBG_data(dbg4)
    );

    mips_regfile_wb #(.RWE_SIZE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .WB_inst_rd_in(rd), .WB_RegWrite_in(we1), .WB_RF_Wdata_in(wdata),
        .ID_rs_addr(rs), .ID_rt_addr(rt),
        .ID_rs_data(rs1), .ID_rt_data(rt1),
        .DBG_addr(dbg), .DBG_data(dbg1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;

        vecs[0]  = '{5'd5,  4'hF, 32'hDEADBEEF, 5'd5,  5'd0,  32'hDEADBEEF, 32'h00000000};
        vecs[1]  = '{5'd0,  4'h0, 32'h00000000, 5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF};
        vecs[2]  = '{5'd0,  4'hF, 32'hFFFFFFFF, 5'd0,  5'd5,  32'h00000000, 32'hDEADBEEF};
        vecs[3]  = '{5'd0,  4'h0, 32'h00000000, 5'd0,  5'd0,  32'h00000000, 32'h00000000};
        vecs[4]  = '{5'd3,  4'hF, 32'h33333333, 5'd1,  5'd2,  32'h00000000, 32'h00000000};
        vecs[5]  = '{5'd7,  4'hF, 32'h11111111, 5'd7,  5'd1,  32'h11111111, 32'h00000000};
        vecs[6]  = '{5'd7,  4'hF, 32'h22222222, 5'd7,  5'd3,  32'h22222222, 32'h33333333};
        vecs[7]  = '{5'd9,  4'hF, 32'hAABBCCDD, 5'd9,  5'd7,  32'hAABBCCDD, 32'h22222222};
        vecs[8]  = '{5'd9,  4'h5, 32'h11223344, 5'd9,  5'd9,  32'hAA22CC44, 32'hAA22CC44};
        vecs[9]  = '{5'd0,  4'h0, 32'h00000000, 5'd9,  5'd5,  32'hAA22CC44, 32'hDEADBEEF};
        vecs[10] = '{5'd9,  4'h8, 32'h55000000, 5'd9,  5'd0,  32'h5522CC44, 32'h00000000};
        vecs[11] = '{5'd9,  4'h1, 32'h000000EE, 5'd9,  5'd3,  32'h5522CCEE, 32'h33333333};
        vecs[12] = '{5'd31, 4'h0, 32'hCAFEF00D, 5'd31, 5'd9,  32'h00000000, 32'h5522CCEE};
        vecs[13] = '{5'd31, 4'hF, 32'hCAFEF00D, 5'd31, 5'd30, 32'hCAFEF00D, 32'h00000000};
        vecs[14] = '{5'd0,  4'h0, 32'h00000000, 5'd31, 5'd31, 32'hCAFEF00D, 32'hCAFEF00D};

        // Initial reset with a write attempt presented: read ports must stay at zero.
        rst_n = 1'b0; rd = 5'd4; we = 4'hF; we1 = 1'b1; wdata = 32'h12345678;
        rs = 5'd4; rt = 5'd4; dbg = 5'd4;
        #1;
        check("rst_rs4", rs4, 32'h0);
        check("rst_rt4", rt4, 32'h0);
        check("rst_rs1", rs1, 32'h0);
        repeat (2) @(negedge clk);
        #1;
        check("rst_dbg4", dbg4, 32'h0);
        check("rst_dbg1", dbg1, 32'h0);
        rst_n = 1'b1; rd = 5'd0; we = 4'h0; we1 = 1'b0; wdata = 32'h0; dbg = 5'd0;

        // Table: writes, r0 protection, bypass and byte lanes.
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            rd = vecs[i].rd; we = vecs[i].we; wdata = vecs[i].wdata;
            rs = vecs[i].rs; rt = vecs[i].rt;
            #1;
            check($sformatf("vec%0d_rs", i), rs4, vecs[i].exp_rs);
            check($sformatf("vec%0d_rt", i), rt4, vecs[i].exp_rt);
        end

        // Debug port reads storage one cycle late and does not bypass.
        @(negedge clk);
        rd = 5'd7; we = 4'hF; wdata = 32'h77777777; rs = 5'd7; rt = 5'd0; dbg = 5'd7;
        #1;
        check("dbg_seq_bypass", rs4, 32'h77777777);
        @(negedge clk);
        rd = 5'd0; we = 4'h0; wdata = 32'h0;
        #1;
        check("dbg_old_r7", dbg4, 32'h22222222);
        @(negedge clk);
        dbg = 5'd5;
        #1;
        check("dbg_new_r7", dbg4, 32'h77777777);
        @(negedge clk);
        dbg = 5'd0;
        #1;
        check("dbg_r5", dbg4, 32'hDEADBEEF);
        @(negedge clk);
        #1;
        check("dbg_r0", dbg4, 32'h0);

        // Word-enable instance: one enable bit covers all four bytes.
        @(negedge clk);
        rd = 5'd12; wdata = 32'h13572468; we1 = 1'b1; we = 4'h0; rs = 5'd12; rt = 5'd12;
        #1;
        check("w1_bypass", rs1, 32'h13572468);
        check("w4_nolane", rs4, 32'h0);
        @(negedge clk);
        we1 = 1'b0; wdata = 32'hFFFFFFFF;
        #1;
        check("w1_stored", rs1, 32'h13572468);
        check("w4_r12", rt4, 32'h0);
        @(negedge clk);
        rd = 5'd0; we1 = 1'b1; rs = 5'd0; rt = 5'd12;
        #1;
        check("w1_r0", rs1, 32'h0);
        check("w1_r12_kept", rt1, 32'h13572468);

        // Reset collision: the write in the reset cycle is lost and the outputs read zero.
        @(negedge clk);
        rst_n = 1'b0; rd = 5'd4; we = 4'hF; we1 = 1'b1; wdata = 32'h12345678;
        rs = 5'd4; rt = 5'd4;
        #1;
        check("coll_rs4", rs4, 32'h0);
        check("coll_rt4", rt4, 32'h0);
        check("coll_rs1", rs1, 32'h0);
        check("coll_rt1", rt1, 32'h0);
        @(negedge clk);
        #1;
        check("coll_rs4_b", rs4, 32'h0);
        @(negedge clk);
        rst_n = 1'b1; rd = 5'd0; we = 4'h0; we1 = 1'b0; wdata = 32'h0;
        for (int i = 1; i < 32; i++) begin
            @(negedge clk);
            rs = 5'(i); rt = 5'(i); dbg = 5'(i);
            #1;
            check($sformatf("clr_rs4_r%0d", i), rs4, 32'h0);
            check($sformatf("clr_rt4_r%0d", i), rt4, 32'h0);
            check($sformatf("clr_rs1_r%0d", i), rs1, 32'h0);
            check($sformatf("clr_dbg4_r%0d", i - 1), dbg4, 32'h0);
        end
        @(negedge clk);
        #1;
        check("clr_dbg4_r31", dbg4, 32'h0);
        check("clr_dbg1_r31", dbg1, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
